// File: rtl/mic_direction_tracker_pkg.sv
// Shared direction codes, FSM encoding and window classifier for the mic direction tracker.
package mic_direction_tracker_pkg;

  localparam int unsigned AMP_W = 16;

  localparam logic [1:0] DIR_NONE   = 2'b00;
  localparam logic [1:0] DIR_LEFT   = 2'b01;
  localparam logic [1:0] DIR_RIGHT  = 2'b10;
  localparam logic [1:0] DIR_CENTER = 2'b11;

  typedef enum logic [1:0] {
    ST_WAIT    = 2'd0,
    ST_ACCUM   = 2'd1,
    ST_COMPUTE = 2'd2,
    ST_DECIDE  = 2'd3
  } state_e;

  // Center when the difference is within a fraction of the louder side.
  function automatic logic [1:0] classify(input logic [AMP_W-1:0] l,
                                          input logic [AMP_W-1:0] r,
                                          input int unsigned      shift);
    logic [AMP_W-1:0] mx;
    logic [AMP_W-1:0] diff;
    mx   = (l > r) ? l : r;
    diff = (l > r) ? (l - r) : (r - l);
    if (l == '0 && r == '0) return DIR_NONE;
    if (diff <= (mx >> shift)) return DIR_CENTER;
    return (l > r) ? DIR_LEFT : DIR_RIGHT;
  endfunction

endpackage

// File: rtl/mic_direction_tracker_done_edge_capture.sv
// One side of the frame pairing: detects a done rise, latches the amplitude and holds a got flag.
module mic_direction_tracker_done_edge_capture
  import mic_direction_tracker_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             done_i,
  input  logic [AMP_W-1:0] amp_i,
  input  logic             clear_i,
  output logic             got_o,
  output logic [AMP_W-1:0] amp_o
);

  logic             done_prev_q;
  logic             got_q, got_d;
  logic [AMP_W-1:0] amp_q, amp_d;
  logic             rise_c;

  // A new rise wins over a clear in the same cycle so no frame is lost.
  always_comb begin
    rise_c = done_i & ~done_prev_q;
    got_d  = got_q;
    amp_d  = amp_q;
    if (clear_i) got_d = 1'b0;
    if (rise_c) begin
      got_d = 1'b1;
      amp_d = amp_i;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      done_prev_q <= 1'b0;
      got_q       <= 1'b0;
      amp_q       <= '0;
    end else begin
      done_prev_q <= done_i;
      got_q       <= got_d;
      amp_q       <= amp_d;
    end
  end

  assign got_o = got_q;
  assign amp_o = amp_q;

endmodule

// File: rtl/mic_direction_tracker.sv
// Pairs left/right frames, averages a window of pairs, classifies direction and applies
// confirm-count hysteresis before changing the reported direction.
module mic_direction_tracker
  import mic_direction_tracker_pkg::*;
#(
  parameter int unsigned AVG_LOG2       = 2,
  parameter int unsigned DEADBAND_SHIFT = 3,
  parameter int unsigned CONFIRM        = 2,
  parameter int unsigned TIMEOUT        = 1000000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [AMP_W-1:0] left_amplitude,
  input  logic             left_done,
  input  logic [AMP_W-1:0] right_amplitude,
  input  logic             right_done,
  output logic [1:0]       direction,
  output logic             valid,
  output logic [AMP_W-1:0] left_avg,
  output logic [AMP_W-1:0] right_avg,
  output logic             timeout_err
);

  localparam int unsigned SUM_W  = AMP_W + AVG_LOG2;
  localparam int unsigned CNT_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int unsigned TMR_W  = $clog2(TIMEOUT + 1);
  localparam int unsigned CONF_W = 4;
  localparam logic [CNT_W-1:0] LAST_FRAME = CNT_W'((1 << AVG_LOG2) - 1);

  logic             got_l, got_r;
  logic [AMP_W-1:0] cap_l, cap_r;
  logic             clear_c;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic [SUM_W-1:0]  sum_l_q, sum_l_d, sum_r_q, sum_r_d;
  logic [TMR_W-1:0]  timer_q, timer_d, timer_inc;
  logic [1:0]        cand_q, cand_d, prev_cand_q, prev_cand_d;
  logic [CONF_W-1:0] confirm_q, confirm_d;
  logic [1:0]        direction_q, direction_d;
  logic              valid_q, valid_d;
  logic [AMP_W-1:0]  left_avg_q, left_avg_d, right_avg_q, right_avg_d;
  logic              timeout_err_q, timeout_err_d;

  mic_direction_tracker_done_edge_capture u_cap_left (
    .clock   (clock),
    .reset   (reset),
    .done_i  (left_done),
    .amp_i   (left_amplitude),
    .clear_i (clear_c),
    .got_o   (got_l),
    .amp_o   (cap_l)
  );

  mic_direction_tracker_done_edge_capture u_cap_right (
    .clock   (clock),
    .reset   (reset),
    .done_i  (right_done),
    .amp_i   (right_amplitude),
    .clear_i (clear_c),
    .got_o   (got_r),
    .amp_o   (cap_r)
  );

  always_comb begin
    state_d       = state_q;
    frame_cnt_d   = frame_cnt_q;
    sum_l_d       = sum_l_q;
    sum_r_d       = sum_r_q;
    timer_d       = timer_q;
    timer_inc     = timer_q + TMR_W'(1);
    cand_d        = cand_q;
    prev_cand_d   = prev_cand_q;
    confirm_d     = confirm_q;
    direction_d   = direction_q;
    valid_d       = 1'b0;
    left_avg_d    = left_avg_q;
    right_avg_d   = right_avg_q;
    timeout_err_d = 1'b0;
    clear_c       = 1'b0;

    unique case (state_q)
      ST_WAIT: begin
        if (got_l && got_r) begin
          state_d = ST_ACCUM;
        end else if (got_l ^ got_r) begin
          // Half a pair waiting: drop it once the partner is overdue.
          if (timer_inc == TMR_W'(TIMEOUT)) begin
            clear_c       = 1'b1;
            timeout_err_d = 1'b1;
            timer_d       = '0;
          end else begin
            timer_d = timer_inc;
          end
        end else begin
          timer_d = '0;
        end
      end
      ST_ACCUM: begin
        sum_l_d = sum_l_q + SUM_W'(cap_l);
        sum_r_d = sum_r_q + SUM_W'(cap_r);
        clear_c = 1'b1;
        timer_d = '0;
        if (frame_cnt_q == LAST_FRAME) begin
          frame_cnt_d = '0;
          state_d     = ST_COMPUTE;
        end else begin
          frame_cnt_d = frame_cnt_q + CNT_W'(1);
          state_d     = ST_WAIT;
        end
      end
      ST_COMPUTE: begin
        left_avg_d  = AMP_W'(sum_l_q >> AVG_LOG2);
        right_avg_d = AMP_W'(sum_r_q >> AVG_LOG2);
        cand_d      = classify(left_avg_d, right_avg_d, DEADBAND_SHIFT);
        sum_l_d     = '0;
        sum_r_d     = '0;
        state_d     = ST_DECIDE;
      end
      ST_DECIDE: begin
        if (cand_q == prev_cand_q) begin
          if (confirm_q < CONF_W'(CONFIRM)) confirm_d = confirm_q + CONF_W'(1);
        end else begin
          confirm_d   = CONF_W'(1);
          prev_cand_d = cand_q;
        end
        if (confirm_d >= CONF_W'(CONFIRM)) direction_d = cand_q;
        valid_d = 1'b1;
        state_d = ST_WAIT;
      end
      default: state_d = ST_WAIT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_WAIT;
      frame_cnt_q   <= '0;
      sum_l_q       <= '0;
      sum_r_q       <= '0;
      timer_q       <= '0;
      cand_q        <= DIR_NONE;
      prev_cand_q   <= DIR_NONE;
      confirm_q     <= '0;
      direction_q   <= DIR_NONE;
      valid_q       <= 1'b0;
      left_avg_q    <= '0;
      right_avg_q   <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      frame_cnt_q   <= frame_cnt_d;
      sum_l_q       <= sum_l_d;
      sum_r_q       <= sum_r_d;
      timer_q       <= timer_d;
      cand_q        <= cand_d;
      prev_cand_q   <= prev_cand_d;
      confirm_q     <= confirm_d;
      direction_q   <= direction_d;
      valid_q       <= valid_d;
      left_avg_q    <= left_avg_d;
      right_avg_q   <= right_avg_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign direction   = direction_q;
  assign valid       = valid_q;
  assign left_avg    = left_avg_q;
  assign right_avg   = right_avg_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mic_direction_tracker.sv
// Self-checking bench for mic_direction_tracker: vector table, corner sequences, random windows.
module tb_mic_direction_tracker;

  localparam int unsigned CONFIRM  = 2;
  localparam int unsigned TIMEOUT  = 100;
  localparam int          WIN      = 4;
  localparam int          DB_SHIFT = 3;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] left_amplitude, right_amplitude;
  logic        left_done, right_done;
  logic [1:0]  direction;
  logic        valid;
  logic [15:0] left_avg, right_avg;
  logic        timeout_err;

  always #5 clock = ~clock;

  mic_direction_tracker #(
    .AVG_LOG2       (2),
    .DEADBAND_SHIFT (DB_SHIFT),
    .CONFIRM        (CONFIRM),
    .TIMEOUT        (TIMEOUT)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .left_amplitude  (left_amplitude),
    .left_done       (left_done),
    .right_amplitude (right_amplitude),
    .right_done      (right_done),
    .direction       (direction),
    .valid           (valid),
    .left_avg        (left_avg),
    .right_avg       (right_avg),
    .timeout_err     (timeout_err)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference model: window of pairs, history of window candidates since reset.
  int m_l[$], m_r[$], hist[$];
  int m_dir = 0, m_lavg = 0, m_ravg = 0;

  function automatic int classify_ref(input int l, input int r);
    int mx, diff;
    if (l == 0 && r == 0) return 0;
    mx   = (l > r) ? l : r;
    diff = (l > r) ? l - r : r - l;
    if (diff <= mx / (1 << DB_SHIFT)) return 3;
    return (l > r) ? 1 : 2;
  endfunction

  task automatic model_pair(input int l, input int r, output bit win_done);
    int sl, sr, c, run;
    m_l.push_back(l);
    m_r.push_back(r);
    win_done = 1'b0;
    if (m_l.size() == WIN) begin
      sl = 0; sr = 0;
      foreach (m_l[i]) begin sl += m_l[i]; sr += m_r[i]; end
      m_lavg = sl / WIN;
      m_ravg = sr / WIN;
      c = classify_ref(m_lavg, m_ravg);
      hist.push_back(c);
      run = 0;
      for (int i = hist.size() - 1; i >= 0 && hist[i] == c; i--) run++;
      if (run >= int'(CONFIRM)) m_dir = c;
      m_l.delete();
      m_r.delete();
      win_done = 1'b1;
    end
  endtask

  task automatic model_reset();
    m_l.delete(); m_r.delete(); hist.delete();
    m_dir = 0; m_lavg = 0; m_ravg = 0;
  endtask

  task automatic check_window(input bit win);
    chk("valid", valid, win);
    chk("timeout_err_idle", timeout_err, 0);
    if (win) begin
      chk("direction", direction, m_dir);
      chk("left_avg", left_avg, m_lavg);
      chk("right_avg", right_avg, m_ravg);
    end
  endtask

  // Called right after the edge that sampled the later done rise.
  task automatic finish_pair(input bit win);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("valid_early", valid, 0);
    end
    tick();
    check_window(win);
  endtask

  task automatic do_pair(input int l, input int r, input int skew, input bit right_first);
    bit win;
    left_amplitude  = 16'(l);
    right_amplitude = 16'(r);
    if (skew == 0) begin
      left_done = 1'b1; right_done = 1'b1;
      tick();
      left_done = 1'b0; right_done = 1'b0;
    end else begin
      if (right_first) right_done = 1'b1; else left_done = 1'b1;
      tick();
      right_done = 1'b0; left_done = 1'b0;
      repeat (skew - 1) tick();
      if (right_first) left_done = 1'b1; else right_done = 1'b1;
      tick();
      right_done = 1'b0; left_done = 1'b0;
    end
    model_pair(l, r, win);
    finish_pair(win);
  endtask

  task automatic do_timeout(input bit right_side);
    int first, cnt, vcnt;
    first = 0; cnt = 0; vcnt = 0;
    left_amplitude  = 16'd12345;
    right_amplitude = 16'd23456;
    if (right_side) right_done = 1'b1; else left_done = 1'b1;
    tick();
    left_done = 1'b0; right_done = 1'b0;
    for (int i = 1; i <= int'(TIMEOUT) + 5; i++) begin
      tick();
      if (timeout_err === 1'b1) begin
        if (first == 0) first = i;
        cnt++;
      end
      if (valid !== 1'b0) vcnt++;
    end
    chk("timeout_delay", first, TIMEOUT);
    chk("timeout_width", cnt, 1);
    chk("timeout_no_valid", vcnt, 0);
  endtask

  typedef struct {
    int l;
    int r;
    int skew;
    bit exp_valid;
    int exp_dir;
    int exp_lavg;
    int exp_ravg;
  } vec_t;

  vec_t vecs[$];

  task automatic add_window(input int l, input int r, input int dir);
    vec_t v;
    for (int i = 0; i < WIN; i++) begin
      v.l = l; v.r = r; v.skew = i;
      v.exp_valid = (i == WIN - 1);
      v.exp_dir = dir; v.exp_lavg = l; v.exp_ravg = r;
      vecs.push_back(v);
    end
  endtask

  function automatic int clamp16(input int x);
    if (x < 0) return 0;
    if (x > 65535) return 65535;
    return x;
  endfunction

  initial begin
    bit win;
    int vcnt, lb, rb, regime;

    reset = 1'b1;
    left_amplitude = '0; right_amplitude = '0;
    left_done = 1'b0; right_done = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("reset_direction", direction, 0);
    chk("reset_valid", valid, 0);
    chk("reset_left_avg", left_avg, 0);
    chk("reset_right_avg", right_avg, 0);
    chk("reset_timeout_err", timeout_err, 0);

    // Hysteresis, deadband and deadband edge windows.
    add_window(8000, 2000, 0);
    add_window(8000, 2000, 1);
    add_window(6000, 5400, 1);
    add_window(6000, 5400, 3);
    add_window(6000, 5200, 3);
    add_window(6000, 5200, 1);
    add_window(8000, 7000, 1);
    add_window(8000, 7000, 3);
    add_window(8000, 6999, 3);
    add_window(8000, 6999, 1);
    foreach (vecs[i]) begin
      do_pair(vecs[i].l, vecs[i].r, vecs[i].skew, vecs[i].skew[0]);
      chk("tbl_valid", valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid) begin
        chk("tbl_direction", direction, vecs[i].exp_dir);
        chk("tbl_left_avg", left_avg, vecs[i].exp_lavg);
        chk("tbl_right_avg", right_avg, vecs[i].exp_ravg);
      end
    end

    // Dropped half-pair, then a full window.
    do_timeout(1'b0);
    for (int i = 0; i < WIN; i++) do_pair(1000, 1000, 1, 1'b0);

    // Simultaneous rise with a long left level, then a left overwrite.
    left_amplitude = 16'd3000; right_amplitude = 16'd9000;
    left_done = 1'b1; right_done = 1'b1;
    tick();
    right_done = 1'b0;
    model_pair(3000, 9000, win);
    vcnt = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (valid !== 1'b0) vcnt++;
    end
    chk("held_done_no_valid", vcnt, 0);
    left_done = 1'b0;
    tick();
    left_amplitude = 16'd60000; left_done = 1'b1; tick();
    left_done = 1'b0; tick();
    left_amplitude = 16'd100; left_done = 1'b1; tick();
    left_done = 1'b0; tick();
    right_amplitude = 16'd200; right_done = 1'b1; tick();
    right_done = 1'b0;
    model_pair(100, 200, win);
    finish_pair(win);
    do_pair(500, 700, 0, 1'b0);
    do_pair(500, 700, 2, 1'b1);

    // Next pair's edges land during COMPUTE and DECIDE.
    for (int i = 0; i < WIN - 1; i++) do_pair(4000, 3000, 1, 1'b1);
    left_amplitude = 16'd4000; right_amplitude = 16'd3000;
    left_done = 1'b1; right_done = 1'b1;
    tick();
    left_done = 1'b0; right_done = 1'b0;
    model_pair(4000, 3000, win);
    tick(); chk("ovl_valid_k1", valid, 0);
    tick(); chk("ovl_valid_k2", valid, 0);
    left_amplitude = 16'd1234; left_done = 1'b1;
    tick(); chk("ovl_valid_k3", valid, 0);
    left_done = 1'b0;
    right_amplitude = 16'd4321; right_done = 1'b1;
    tick();
    check_window(win);
    right_done = 1'b0;
    model_pair(1234, 4321, win);
    finish_pair(win);
    for (int i = 0; i < WIN - 1; i++) do_pair(2000, 2500, 0, 1'b0);

    // Reset mid-window discards the partial sums.
    do_pair(30000, 100, 0, 1'b0);
    do_pair(30000, 100, 1, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midreset_direction", direction, 0);
    chk("midreset_valid", valid, 0);
    chk("midreset_left_avg", left_avg, 0);
    chk("midreset_right_avg", right_avg, 0);
    chk("midreset_timeout_err", timeout_err, 0);
    model_reset();
    for (int i = 0; i < 2 * WIN; i++) do_pair(0, 0, i % 3, 1'b1);

    // Random windows with occasional dropped half-pairs.
    for (int w = 0; w < 30; w++) begin
      regime = $urandom_range(0, 3);
      lb = $urandom_range(1000, 60000);
      case (regime)
        0: begin lb = 0; rb = 0; end
        1: rb = lb - lb / 20;
        2: rb = $urandom_range(0, 65535);
        default: rb = lb - lb / 8 + $urandom_range(0, 8) - 4;
      endcase
      for (int p = 0; p < WIN; p++) begin
        if ($urandom_range(0, 19) == 0) do_timeout($urandom_range(0, 1) == 1);
        if (regime == 0)
          do_pair(0, 0, $urandom_range(0, 4), $urandom_range(0, 1) == 1);
        else
          do_pair(clamp16(lb + $urandom_range(0, 40)), clamp16(rb + $urandom_range(0, 40)),
                  $urandom_range(0, 4), $urandom_range(0, 1) == 1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
